univ_shift_reg_n: RTL

- Parametrised successor to the team's 4-bit 74HC194-style universal shift register.
- Width-generic; keeps the four 194 modes (hold / shift right / shift left / parallel load).
- Adds rotate mode, serial cascade outputs and a multi-step "shift by count" sequencer with busy/done handshake.
- Used wherever a datapath needs an N-bit serialiser/deserialiser or barrel-style shift over several cycles.

---
 rtl/univ_shift_reg_n.sv | 115 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg_n.sv
// rtl/univ_shift_reg_n.sv - parametrised 194-style universal shift register with rotate and multi-step shift sequencer
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             CR_n,
    input  logic [1:0]       S,
    input  logic             ROT,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] Q,
    output logic             QSR,
    output logic             QSL,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic             dir_left, dir_left_nxt;
    logic             rot_lat, rot_lat_nxt;

    // Right shift moves data toward the high index; left toward index 0.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] q,
        input logic             left,
        input logic             rot,
        input logic             dsr,
        input logic             dsl
    );
        if (left)
            return {(rot ? q[0] : dsl), q[WIDTH-1:1]};
        else
            return {q[WIDTH-2:0], (rot ? q[WIDTH-1] : dsr)};
    endfunction

    always_ff @(posedge CP or negedge CR_n) begin
        if (!CR_n) begin
            state    <= IDLE;
            Q        <= '0;
            rem      <= '0;
            dir_left <= 1'b0;
            rot_lat  <= 1'b0;
        end else begin
            state    <= state_nxt;
            Q        <= q_nxt;
            rem      <= rem_nxt;
            dir_left <= dir_left_nxt;
            rot_lat  <= rot_lat_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        q_nxt        = Q;
        rem_nxt      = rem;
        dir_left_nxt = dir_left;
        rot_lat_nxt  = rot_lat;
        case (state)
            IDLE: begin
                if (start && (S == 2'b01 || S == 2'b10)) begin
                    dir_left_nxt = (S == 2'b10);
                    rot_lat_nxt  = ROT;
                    if (count == '0) begin
                        state_nxt = DONE;
                    end else begin
                        // The accepting edge performs the first of the shifts.
                        q_nxt     = shift_step(Q, S == 2'b10, ROT, DSR, DSL);
                        rem_nxt   = count - CNT_W'(1);
                        state_nxt = (count == CNT_W'(1)) ? DONE : RUN;
                    end
                end else begin
                    case (S)
                        2'b01:   q_nxt = shift_step(Q, 1'b0, ROT, DSR, DSL);
                        2'b10:   q_nxt = shift_step(Q, 1'b1, ROT, DSR, DSL);
                        2'b11:   q_nxt = D;
                        default: q_nxt = Q;
                    endcase
                end
            end
            RUN: begin
                q_nxt   = shift_step(Q, dir_left, rot_lat, DSR, DSL);
                rem_nxt = rem - CNT_W'(1);
                if (rem == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    assign QSR = Q[WIDTH-1];
    assign QSL = Q[0];

endmodule
